uram_cascade_bank: RTL and testbench

Parametrised dual-port cascaded memory bank for the UDP shell datapath. It stitches `CASCADE_LEVEL` URAM-sized blocks into one address space behind two independent ports, A and B. Each port has a fixed-latency read pipeline, per-byte write enables, deterministic cross-port collision resolution and an out-of-range flag. It replaces the fixed-width cascade wrapper and feeds the packet-buffer and lookup-table logic.

---
 rtl/uram_cascade_bank_if.sv | 26 ++
 rtl/uram_cascade_bank.sv | 121 ++++++++++++
 tb/tb_uram_cascade_bank.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uram_cascade_bank_if.sv
// rtl/uram_cascade_bank_if.sv - one request/response port of the cascaded memory bank
interface uram_cascade_bank_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 72
);
   localparam int BWE_W = DATA_W / 8;

   logic              en;
   logic              rdb_wr;
   logic [ADDR_W-1:0] addr;
   logic [BWE_W-1:0]  bwe;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic              rdaccess;
   logic              addr_err;

   modport master (
      output en, rdb_wr, addr, bwe, din,
      input  dout, rdaccess, addr_err
   );

   modport slave (
      input  en, rdb_wr, addr, bwe, din,
      output dout, rdaccess, addr_err
   );
endinterface

// File: rtl/uram_cascade_bank.sv
// rtl/uram_cascade_bank.sv - dual-port cascade of URAM-sized blocks, fixed latency CASCADE_LEVEL+1
module uram_cascade_bank #(
   parameter int CASCADE_LEVEL = 4,
   parameter int BLOCK_AW      = 12,
   parameter int DATA_W        = 72,
   parameter int ADDR_W        = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   uram_cascade_bank_if.slave   port_a,
   uram_cascade_bank_if.slave   port_b
);
   localparam int BWE_W = DATA_W / 8;
   localparam int NS    = CASCADE_LEVEL + 1;
   localparam int LAST  = CASCADE_LEVEL;
   localparam int BLK_W = ADDR_W - BLOCK_AW;
   localparam int DEPTH = 1 << BLOCK_AW;

   logic              in_en   [2];
   logic              in_wr   [2];
   logic [ADDR_W-1:0] in_addr [2];
   logic [BWE_W-1:0]  in_bwe  [2];
   logic [DATA_W-1:0] in_din  [2];

   assign in_en[0]   = port_a.en;
   assign in_wr[0]   = port_a.rdb_wr;
   assign in_addr[0] = port_a.addr;
   assign in_bwe[0]  = port_a.bwe;
   assign in_din[0]  = port_a.din;
   assign in_en[1]   = port_b.en;
   assign in_wr[1]   = port_b.rdb_wr;
   assign in_addr[1] = port_b.addr;
   assign in_bwe[1]  = port_b.bwe;
   assign in_din[1]  = port_b.din;

   // Stage s register holds a request that will touch block s at the next edge.
   logic                vld   [2][NS];
   logic                op_wr [2][NS];
   logic [BLOCK_AW-1:0] row   [2][NS];
   logic [BLK_W-1:0]    blk   [2][NS];
   logic [BWE_W-1:0]    bwe   [2][NS];
   logic [DATA_W-1:0]   dat   [2][NS];

   logic                hit   [2][CASCADE_LEVEL];
   logic                oor   [2];

   logic [DATA_W-1:0]   mem   [CASCADE_LEVEL][DEPTH];

   logic [DATA_W-1:0]   dout  [2];
   logic                rdacc [2];
   logic                aerr  [2];

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < CASCADE_LEVEL; i++) begin
            hit[p][i] = vld[p][i] && (blk[p][i] == BLK_W'(i));
         end
         // Extra bit keeps CASCADE_LEVEL == 2**BLK_W from wrapping to zero.
         oor[p] = {1'b0, blk[p][LAST]} >= (BLK_W + 1)'(CASCADE_LEVEL);
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         op_wr[p][0] <= in_wr[p];
         row[p][0]   <= in_addr[p][BLOCK_AW-1:0];
         blk[p][0]   <= in_addr[p][ADDR_W-1:BLOCK_AW];
         bwe[p][0]   <= in_bwe[p];
         dat[p][0]   <= in_din[p];
         for (int i = 0; i < CASCADE_LEVEL; i++) begin
            op_wr[p][i+1] <= op_wr[p][i];
            row[p][i+1]   <= row[p][i];
            blk[p][i+1]   <= blk[p][i];
            bwe[p][i+1]   <= bwe[p][i];
            dat[p][i+1]   <= (hit[p][i] && !op_wr[p][i]) ? mem[i][row[p][i]] : dat[p][i];
         end
      end
      // Port B is applied first so port A's bytes win on a same-address collision.
      for (int i = 0; i < CASCADE_LEVEL; i++) begin
         for (int p = 1; p >= 0; p--) begin
            for (int k = 0; k < BWE_W; k++) begin
               if (hit[p][i] && op_wr[p][i] && bwe[p][i][k]) begin
                  mem[i][row[p][i]][8*k +: 8] <= dat[p][i][8*k +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NS; s++) begin
               vld[p][s] <= 1'b0;
            end
            dout[p]  <= '0;
            rdacc[p] <= 1'b0;
            aerr[p]  <= 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            vld[p][0] <= in_en[p];
            for (int s = 0; s < LAST; s++) begin
               vld[p][s+1] <= vld[p][s];
            end
            rdacc[p] <= vld[p][LAST] && !op_wr[p][LAST];
            aerr[p]  <= vld[p][LAST] && oor[p];
            if (vld[p][LAST] && !op_wr[p][LAST]) begin
               dout[p] <= oor[p] ? '0 : dat[p][LAST];
            end
         end
      end
   end

   assign port_a.dout     = dout[0];
   assign port_a.rdaccess = rdacc[0];
   assign port_a.addr_err = aerr[0];
   assign port_b.dout     = dout[1];
   assign port_b.rdaccess = rdacc[1];
   assign port_b.addr_err = aerr[1];
endmodule

// File: tb/tb_uram_cascade_bank.sv
// tb/tb_uram_cascade_bank.sv - bench for uram_cascade_bank at CASCADE_LEVEL 4, 1 and 16
module tb_uram_cascade_bank;
   logic clk;
   logic rst;

   logic        t_en   [3][2];
   logic        t_wr   [3][2];
   logic [22:0] t_addr [3][2];
   logic [8:0]  t_bwe  [3][2];
   logic [71:0] t_din  [3][2];
   logic [71:0] o_dout [3][2];
   logic        o_acc  [3][2];
   logic        o_err  [3][2];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int LV = (g == 0) ? 4 : (g == 1) ? 1 : 16;
      uram_cascade_bank_if #(.ADDR_W(23), .DATA_W(72)) pa ();
      uram_cascade_bank_if #(.ADDR_W(23), .DATA_W(72)) pb ();
      assign pa.en = t_en[g][0];   assign pa.rdb_wr = t_wr[g][0];   assign pa.addr = t_addr[g][0];
      assign pa.bwe = t_bwe[g][0]; assign pa.din = t_din[g][0];
      assign pb.en = t_en[g][1];   assign pb.rdb_wr = t_wr[g][1];   assign pb.addr = t_addr[g][1];
      assign pb.bwe = t_bwe[g][1]; assign pb.din = t_din[g][1];
      assign o_dout[g][0] = pa.dout; assign o_acc[g][0] = pa.rdaccess; assign o_err[g][0] = pa.addr_err;
      assign o_dout[g][1] = pb.dout; assign o_acc[g][1] = pb.rdaccess; assign o_err[g][1] = pb.addr_err;
      uram_cascade_bank #(.CASCADE_LEVEL(LV), .BLOCK_AW(12), .DATA_W(72), .ADDR_W(23)) dut (
         .clk    (clk),
         .rst    (rst),
         .port_a (pa),
         .port_b (pb)
      );
   end

   function automatic int lvl(int c);
      return (c == 0) ? 4 : (c == 1) ? 1 : 16;
   endfunction

   function automatic logic [71:0] bytemask(bit [8:0] m);
      logic [71:0] r;
      for (int k = 0; k < 9; k++) r[8*k +: 8] = {8{m[k]}};
      return r;
   endfunction

   task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: a flat word memory updated once per cycle; reads see the state before
   // this cycle's writes, B's bytes land first and A's bytes overwrite them.
   typedef struct {
      bit        v;
      bit        acc;
      bit        err;
      bit [71:0] d;
      bit [8:0]  m;
   } exp_t;

   exp_t       ring  [3][2][32];
   bit [71:0]  mdat  [longint];
   bit [8:0]   mknw  [longint];

   task automatic model_issue(int c);
      int        slot;
      int        blk;
      bit        oor;
      longint    key;
      exp_t      e;
      bit [71:0] d;
      bit [8:0]  m;
      slot = (cyc + lvl(c) + 1) % 32;
      for (int p = 0; p < 2; p++) begin
         if (t_en[c][p]) begin
            blk   = int'(t_addr[c][p] >> 12);
            oor   = blk >= lvl(c);
            key   = longint'(c) * 64'd16777216 + longint'(t_addr[c][p]);
            e.v   = 1'b1;
            e.acc = !t_wr[c][p];
            e.err = oor;
            e.d   = '0;
            e.m   = 9'h1FF;
            if (!oor && !t_wr[c][p]) begin
               e.d = mdat.exists(key) ? mdat[key] : 72'h0;
               e.m = mknw.exists(key) ? mknw[key] : 9'h0;
            end
            ring[c][p][slot] = e;
         end
      end
      for (int p = 1; p >= 0; p--) begin
         blk = int'(t_addr[c][p] >> 12);
         key = longint'(c) * 64'd16777216 + longint'(t_addr[c][p]);
         if (t_en[c][p] && t_wr[c][p] && blk < lvl(c)) begin
            d = mdat.exists(key) ? mdat[key] : 72'h0;
            m = mknw.exists(key) ? mknw[key] : 9'h0;
            for (int k = 0; k < 9; k++) begin
               if (t_bwe[c][p][k]) begin
                  d[8*k +: 8] = t_din[c][p][8*k +: 8];
                  m[k]        = 1'b1;
               end
            end
            mdat[key] = d;
            mknw[key] = m;
         end
      end
   endtask

   always @(posedge clk) begin
      int   s;
      exp_t e;
      cyc++;
      if (!rst) begin
         for (int c = 0; c < 3; c++)
            for (int p = 0; p < 2; p++)
               for (int i = 0; i < 32; i++) ring[c][p][i].v = 1'b0;
      end else begin
         for (int c = 0; c < 3; c++) model_issue(c);
      end
      #1;
      s = cyc % 32;
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < 2; p++) begin
            e = ring[c][p][s];
            if (e.v) begin
               chk($sformatf("model c%0d p%0d rdaccess", c, p), 72'(o_acc[c][p]), 72'(e.acc));
               chk($sformatf("model c%0d p%0d addr_err", c, p), 72'(o_err[c][p]), 72'(e.err));
               if (e.acc)
                  chk($sformatf("model c%0d p%0d dout", c, p),
                      o_dout[c][p] & bytemask(e.m), e.d & bytemask(e.m));
            end else begin
               chk($sformatf("model c%0d p%0d idle rdaccess", c, p), 72'(o_acc[c][p]), 72'h0);
               chk($sformatf("model c%0d p%0d idle addr_err", c, p), 72'(o_err[c][p]), 72'h0);
            end
            if (!rst) chk($sformatf("model c%0d p%0d reset dout", c, p), o_dout[c][p], 72'h0);
            ring[c][p][s].v = 1'b0;
         end
      end
   end

   task automatic req(int p, bit wr, logic [22:0] a, logic [8:0] be, logic [71:0] d);
      t_en[0][p] = 1'b1; t_wr[0][p] = wr; t_addr[0][p] = a; t_bwe[0][p] = be; t_din[0][p] = d;
   endtask

   task automatic idle();
      for (int c = 0; c < 3; c++)
         for (int p = 0; p < 2; p++) t_en[c][p] = 1'b0;
   endtask

   typedef struct {
      int          p;
      bit          wr;
      logic [22:0] a;
      logic [8:0]  be;
      logic [71:0] din;
      logic [71:0] ed;
      bit          eacc;
      bit          eerr;
   } vec_t;

   localparam int L4 = 5;
   localparam logic [71:0] ONES = 72'hFFFFFFFFFFFFFFFFFF;
   localparam logic [71:0] COL1 = 72'hFFFFFFFFFFAAAA0000;
   localparam logic [71:0] FIVE = 72'h555555555555555555;

   initial begin
      vec_t        vt [10];
      logic [22:0] ba [4];
      logic [71:0] bw [4];
      int          r;

      vt[0] = '{0, 1'b1, 23'h0000, 9'h1FF, 72'hDEADBEEFCAFEF00D12, 72'h0, 1'b0, 1'b0};
      vt[1] = '{0, 1'b0, 23'h0000, 9'h000, 72'h0, 72'hDEADBEEFCAFEF00D12, 1'b1, 1'b0};
      vt[2] = '{1, 1'b1, 23'h1234, 9'h1FF, ONES, 72'h0, 1'b0, 1'b0};
      vt[3] = '{0, 1'b0, 23'h4000, 9'h000, 72'h0, 72'h0, 1'b1, 1'b1};
      vt[4] = '{0, 1'b1, 23'h4000, 9'h1FF, 72'h111111111111111111, 72'h0, 1'b0, 1'b1};
      vt[5] = '{0, 1'b0, 23'h0000, 9'h000, 72'h0, 72'hDEADBEEFCAFEF00D12, 1'b1, 1'b0};
      vt[6] = '{1, 1'b1, 23'h0000, 9'h001, 72'h77, 72'h0, 1'b0, 1'b0};
      vt[7] = '{1, 1'b0, 23'h0000, 9'h000, 72'h0, 72'hDEADBEEFCAFEF00D77, 1'b1, 1'b0};
      vt[8] = '{0, 1'b1, 23'h3FFF, 9'h1FF, 72'h0123456789ABCDEF01, 72'hDEADBEEFCAFEF00D12, 1'b0, 1'b0};
      vt[9] = '{0, 1'b0, 23'h3FFF, 9'h000, 72'h0, 72'h0123456789ABCDEF01, 1'b1, 1'b0};
      ba = '{23'h0FFF, 23'h1000, 23'h2FFF, 23'h3000};
      bw = '{72'h0A0A0A0A0A0A0A0A01, 72'h0B0B0B0B0B0B0B0B02, 72'h0C0C0C0C0C0C0C0C03, 72'h0D0D0D0D0D0D0D0D04};

      for (int c = 0; c < 3; c++)
         for (int p = 0; p < 2; p++) begin
            t_en[c][p] = 1'b0; t_wr[c][p] = 1'b0; t_addr[c][p] = '0; t_bwe[c][p] = '0; t_din[c][p] = '0;
         end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 3; c++)
         for (int p = 0; p < 2; p++) begin
            chk("reset rdaccess", 72'(o_acc[c][p]), 72'h0);
            chk("reset addr_err", 72'(o_err[c][p]), 72'h0);
            chk("reset dout", o_dout[c][p], 72'h0);
         end
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         req(vt[i].p, vt[i].wr, vt[i].a, vt[i].be, vt[i].din);
         @(negedge clk); idle();
         repeat (L4 - 1) @(negedge clk);
         chk($sformatf("vec%0d early rdaccess", i), 72'(o_acc[0][vt[i].p]), 72'h0);
         @(negedge clk);
         chk($sformatf("vec%0d rdaccess", i), 72'(o_acc[0][vt[i].p]), 72'(vt[i].eacc));
         chk($sformatf("vec%0d addr_err", i), 72'(o_err[0][vt[i].p]), 72'(vt[i].eerr));
         chk($sformatf("vec%0d dout", i), o_dout[0][vt[i].p], vt[i].ed);
      end

      // write immediately followed by a read of the same word
      req(0, 1'b1, 23'h0010, 9'h1FF, 72'hC3C3C3C3C3C3C3C3C3);
      @(negedge clk); req(0, 1'b0, 23'h0010, 9'h000, 72'h0);
      @(negedge clk); idle();
      repeat (4) @(negedge clk);
      chk("wr-rd early rdaccess", 72'(o_acc[0][0]), 72'h0);
      @(negedge clk);
      chk("wr-rd rdaccess", 72'(o_acc[0][0]), 72'h1);
      chk("wr-rd dout", o_dout[0][0], 72'hC3C3C3C3C3C3C3C3C3);

      // block boundaries, reads back-to-back on B
      for (int i = 0; i < 4; i++) begin
         idle(); req(0, 1'b1, ba[i], 9'h1FF, bw[i]); @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         idle(); req(1, 1'b0, ba[i], 9'h000, 72'h0); @(negedge clk);
      end
      idle();
      @(negedge clk);
      chk("boundary early rdaccess", 72'(o_acc[0][1]), 72'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("boundary%0d rdaccess", i), 72'(o_acc[0][1]), 72'h1);
         chk($sformatf("boundary%0d dout", i), o_dout[0][1], bw[i]);
         @(negedge clk);
      end

      // collisions on 0x1234 (preloaded with all ones)
      idle(); req(0, 1'b1, 23'h1234, 9'h003, 72'h0); req(1, 1'b1, 23'h1234, 9'h00F, 72'hAAAAAAAAAAAAAAAAAA);
      @(negedge clk); idle(); req(0, 1'b0, 23'h1234, 9'h000, 72'h0);
      @(negedge clk); idle(); req(0, 1'b0, 23'h1234, 9'h000, 72'h0); req(1, 1'b1, 23'h1234, 9'h1FF, FIVE);
      @(negedge clk); idle(); req(0, 1'b0, 23'h1234, 9'h000, 72'h0); req(1, 1'b0, 23'h1234, 9'h000, 72'h0);
      @(negedge clk); idle();
      repeat (3) @(negedge clk);
      chk("wr/wr merge rdaccess", 72'(o_acc[0][0]), 72'h1);
      chk("wr/wr merge dout", o_dout[0][0], COL1);
      @(negedge clk);
      chk("rd/wr read-first dout", o_dout[0][0], COL1);
      @(negedge clk);
      chk("rd/rd A dout", o_dout[0][0], FIVE);
      chk("rd/rd B rdaccess", 72'(o_acc[0][1]), 72'h1);
      chk("rd/rd B dout", o_dout[0][1], FIVE);

      // reset while reads are in flight
      idle(); req(0, 1'b1, 23'h0020, 9'h1FF, 72'h3C3C3C3C3C3C3C3C3C);
      @(negedge clk); idle();
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         req(0, 1'b0, 23'h0020, 9'h000, 72'h0); @(negedge clk);
      end
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async reset dout", o_dout[0][0], 72'h0);
      chk("async reset rdaccess", 72'(o_acc[0][0]), 72'h0);
      chk("async reset addr_err", 72'(o_err[0][0]), 72'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post-reset no rdaccess", 72'(o_acc[0][0]), 72'h0);
      end
      req(0, 1'b0, 23'h0020, 9'h000, 72'h0);
      @(negedge clk); idle();
      repeat (L4) @(negedge clk);
      chk("post-reset rdaccess", 72'(o_acc[0][0]), 72'h1);
      chk("post-reset dout", o_dout[0][0], 72'h3C3C3C3C3C3C3C3C3C);

      // full-rate random traffic on every configuration
      for (int n = 0; n < 10000; n++) begin
         for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 2; p++) begin
               r = int'($urandom_range(0, 3));
               t_en[c][p]   = ($urandom_range(0, 3) != 0);
               t_wr[c][p]   = 1'($urandom_range(0, 1));
               t_addr[c][p] = 23'(int'($urandom_range(0, lvl(c))) * 4096 + ((r == 3) ? 4095 : r));
               t_bwe[c][p]  = 9'($urandom);
               t_din[c][p]  = 72'({$urandom(), $urandom(), $urandom()});
            end
         end
         @(negedge clk);
      end
      idle();
      repeat (24) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
